dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter in front of a single data memory. Port 0 is
//   the load/store unit, port 1 the debug/DMA master. A granted request is
//   latched, checked for alignment/range, optionally held LAT extra cycles in
//   ACCESS, and completed with a one-cycle ack (plus err on a bad address).
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-low reset
//   reqN_i, weN_i              request and write-enable of port N
//   addrN_i, wdataN_i          byte address and write data of port N
//   ackN_o, errN_o             one-cycle completion / error pulse of port N
//   rdataN_o                   read data, valid only with a non-error read ack
//   mem_addr_o, mem_wdata_o    memory address / write data (0 outside ACCESS)
//   mem_we_o, mem_re_o         memory write / read strobes (0 outside ACCESS)
//   mem_data_i                 memory read data, combinational from mem_addr_o
//   busy_o                     high whenever the FSM is not IDLE
module dmem_arbiter #(
  parameter int DEPTH_BYTES = 32,
  parameter int LAT         = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Highest byte address at which a full word still fits in the memory.
  localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [3:0]  LAT_CNT  = 4'(LAT);

  state_t      state_q;
  logic        port_q;
  logic        we_q;
  logic        last_q;     // port served by the most recent transaction
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        ack0_q, ack1_q, err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  // Grant candidate as seen in IDLE.
  logic        gnt_port_d;
  logic        gnt_we_d;
  logic        gnt_err_d;
  logic [31:0] gnt_addr_d;
  logic [31:0] gnt_wdata_d;

  always_comb begin
    // On contention the port that was not served last wins; otherwise the
    // sole requester (port 1 only if port 0 is idle).
    gnt_port_d  = (req0_i && req1_i) ? ~last_q : req1_i;
    gnt_we_d    = gnt_port_d ? we1_i    : we0_i;
    gnt_addr_d  = gnt_port_d ? addr1_i  : addr0_i;
    gnt_wdata_d = gnt_port_d ? wdata1_i : wdata0_i;
    gnt_err_d   = (gnt_addr_d[1:0] != 2'b00) || (gnt_addr_d > MAX_ADDR);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // Response outputs are single-cycle pulses.
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            port_q  <= gnt_port_d;
            we_q    <= gnt_we_d;
            addr_q  <= gnt_addr_d;
            wdata_q <= gnt_wdata_d;
            if (gnt_err_d) begin
              // Bad address: respond immediately, memory never touched.
              state_q <= RESP;
              ack0_q  <= ~gnt_port_d;
              ack1_q  <= gnt_port_d;
              err0_q  <= ~gnt_port_d;
              err1_q  <= gnt_port_d;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= LAT_CNT;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ack0_q  <= ~port_q;
            ack1_q  <= port_q;
            if (!we_q) begin
              if (port_q) rdata1_q <= mem_data_i;
              else        rdata0_q <= mem_data_i;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          last_q  <= port_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory bus is driven from registered state only, so it drops as soon as
  // reset forces the state back to IDLE.
  logic in_access;
  assign in_access   = (state_q == ACCESS);
  assign mem_addr_o  = in_access ? addr_q  : '0;
  assign mem_wdata_o = in_access ? wdata_q : '0;
  assign mem_we_o    = in_access &  we_q;
  assign mem_re_o    = in_access & ~we_q;
  assign busy_o      = (state_q != IDLE);

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign err0_o   = err0_q;
  assign err1_o   = err1_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule
